multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 opcode  in  6  instruction [31:26], sampled in ID.
REQ-005 funct  in  6  instruction [5:0], sampled in ID.
REQ-006 mem_ready  in  1  memory handshake; access completes in a cycle where it is 1.
REQ-007 flag_zero  in  1  ALU zero flag, sampled in EX.
REQ-008 flag_overflow_pos  in  1  ALU overflow flag, sampled in EX.
REQ-009 aluSelect  out  3  ALU op: 000 add, 001 sub, 010 or, 011 slt, 100 add with overflow, 101 lui.
REQ-010 alu_srcB  out  2  ALU B operand: 00 rt, 01 constant 4, 10 sign-extended imm, 11 zero-extended imm.
REQ-011 pc_write, ir_write, mem_read, mem_write, reg_write  out  1 each  single-cycle strobes.
REQ-012 pc_src  out  2  PC source: 00 ALU result, 01 branch target, 10 jump target.
REQ-013 reg_dst  out  1  register destination: 0 rt, 1 rd.
REQ-014 mem_to_reg  out  1  write-back source: 1 memory, 0 ALU.
REQ-015 exc, illegal_op  out  1 each  one-cycle pulses.
REQ-016 state  out  3  current state code.

Function
REQ-017 States and codes SHALL be IF=0, ID=1, EX=2, MEM=3, WB=4, EXC=5; codes 6 and 7 SHALL go to IF on the next clock.
REQ-018 IF SHALL assert mem_read, aluSelect=000 and alu_srcB=01; it SHALL remain in IF while mem_ready=0.
REQ-019 When IF sees mem_ready=1, that cycle SHALL also assert ir_write and pc_write with pc_src=00, then go to ID.
REQ-020 ID SHALL latch opcode/funct into an internal class register and go to EX.
REQ-021 An opcode/funct outside the decode table below SHALL pulse illegal_op in ID and return to IF.
REQ-022 Decode table: R-type (opcode 000000) with funct addu 100001, subu 100011, slt 101010.
REQ-023 Decode table: I/J-type opcodes addi 001000, addiu 001001, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010.
REQ-024 EX selections: addu/addiu/lw/sw use aluSelect=000; subu and beq use 001; ori uses 010; slt uses 011; addi uses 100; lui uses 101.
REQ-025 EX alu_srcB: R-type and beq use 00; addi, addiu, lw and sw use 10; ori and lui use 11.
REQ-026 beq in EX SHALL assert pc_write with pc_src=01 only if flag_zero=1, then go to IF.
REQ-027 j in EX SHALL assert pc_write with pc_src=10, then go to IF.
REQ-028 From EX, lw and sw SHALL go to MEM; all other instructions SHALL go to WB.
REQ-029 MEM SHALL assert mem_read (lw) or mem_write (sw) and hold it, staying in MEM, until mem_ready=1.
REQ-030 On MEM completion, lw SHALL go to WB and sw SHALL go to IF.
REQ-031 WB SHALL assert reg_write for one cycle, with reg_dst=1 for R-type and 0 otherwise, and mem_to_reg=1 for lw only; next state IF.
REQ-032 Latency from IF exit SHALL be: beq/j 3 cycles; R-type, imm-ops and sw 4 cycles; lw 5 cycles (plus any mem_ready wait cycles).
REQ-033 All strobes not listed for a state SHALL be 0 in that state.

Reset
REQ-034 While rst_n=0, state SHALL be IF and the class register cleared.
REQ-035 While rst_n=0, all strobes, exc and illegal_op SHALL be 0, aluSelect=000 and alu_srcB=01.
REQ-036 Reset asserted mid-instruction, including MEM waits, SHALL abort immediately with no write strobe issued.
REQ-037 The first fetch SHALL begin on the first clk edge after rst_n rises.

Configuration
REQ-038 With OVF_TRAP_EN defined, addi with flag_overflow_pos=1 in EX SHALL go to EXC: one cycle, exc=1, reg_write=0, then IF.
REQ-039 Without OVF_TRAP_EN, addi overflow SHALL be ignored: WB proceeds normally, and exc is tied to 0.

Verification
REQ-040 Reset then addu (opcode 000000, funct 100001) with mem_ready=1 -> states 0,1,2,4,0; reg_write=1 in state 4 with reg_dst=1; aluSelect=000 in EX.
REQ-041 lw with mem_ready held 0 for 3 MEM cycles -> mem_read held for 4 cycles, then WB with mem_to_reg=1; total 8 cycles from IF exit.
REQ-042 beq with flag_zero=1 -> pc_write=1, pc_src=01 in EX; repeat with flag_zero=0 -> pc_write=0; both return to IF.
REQ-043 addi with flag_overflow_pos=1 -> with OVF_TRAP_EN: exc pulse and no reg_write; without it: reg_write=1 and exc=0.
REQ-044 opcode 111111 -> illegal_op pulse in ID, next state IF, no write strobes.
REQ-045 rst_n dropped during a MEM wait of sw -> state=0 asynchronously, mem_write=0, and a fresh fetch after release.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control unit.
//
// Sequences each instruction through IF -> ID -> EX [-> MEM] [-> WB] and drives the
// datapath control strobes for the current state. The instruction class is decoded
// once in ID and held in a class register for the rest of the instruction.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   opcode, funct      instruction fields, sampled in ID
//   mem_ready          memory handshake; an access completes in a cycle where it is 1
//   flag_zero          ALU zero flag, used by beq in EX
//   flag_overflow_pos  ALU overflow flag, used by addi in EX
//   aluSelect          ALU op (000 add, 001 sub, 010 or, 011 slt, 100 add/ovf, 101 lui)
//   alu_srcB           ALU B operand (00 rt, 01 const 4, 10 sext imm, 11 zext imm)
//   pc_write, ir_write, mem_read, mem_write, reg_write   single-cycle strobes
//   pc_src             PC source (00 ALU, 01 branch target, 10 jump target)
//   reg_dst            write-back register (0 rt, 1 rd)
//   mem_to_reg         write-back source (1 memory, 0 ALU)
//   exc, illegal_op    one-cycle pulses
//   state              current state code
//
// Build option: define OVF_TRAP_EN to trap signed overflow on addi into the EXC state.
// Without it, addi overflow is ignored and exc is tied to 0.

module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  input  logic       flag_zero,
  input  logic       flag_overflow_pos,
  output logic [2:0] aluSelect,
  output logic [1:0] alu_srcB,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] pc_src,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       exc,
  output logic       illegal_op,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StEx  = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4,
    StExc = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ClsNone, ClsAddu, ClsSubu, ClsSlt, ClsAddi, ClsAddiu,
    ClsOri, ClsLui, ClsLw, ClsSw, ClsBeq, ClsJ
  } cls_e;

  state_e state_q, state_d;
  cls_e   cls_q, cls_d, dec_cls;
  logic   exc_c;

  // Instruction decode; anything outside the table maps to ClsNone (illegal).
  always_comb begin
    dec_cls = ClsNone;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100001: dec_cls = ClsAddu;
          6'b100011: dec_cls = ClsSubu;
          6'b101010: dec_cls = ClsSlt;
          default:   dec_cls = ClsNone;
        endcase
      end
      6'b001000: dec_cls = ClsAddi;
      6'b001001: dec_cls = ClsAddiu;
      6'b001101: dec_cls = ClsOri;
      6'b001111: dec_cls = ClsLui;
      6'b100011: dec_cls = ClsLw;
      6'b101011: dec_cls = ClsSw;
      6'b000100: dec_cls = ClsBeq;
      6'b000010: dec_cls = ClsJ;
      default:   dec_cls = ClsNone;
    endcase
  end

  assign cls_d = (state_q == StId) ? dec_cls : cls_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIf;
      cls_q   <= ClsNone;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  always_comb begin
    state_d    = StIf;
    aluSelect  = 3'b000;
    alu_srcB   = 2'b01;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    pc_src     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    exc_c      = 1'b0;
    illegal_op = 1'b0;
    // Outputs are gated by rst_n so an asynchronous reset kills every strobe at once,
    // including the IF fetch strobes that the reset state would otherwise drive.
    if (rst_n) begin
      case (state_q)
        StIf: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = StId;
          end else begin
            state_d  = StIf;
          end
        end
        StId: begin
          if (dec_cls == ClsNone) begin
            illegal_op = 1'b1;
            state_d    = StIf;
          end else begin
            state_d    = StEx;
          end
        end
        StEx: begin
          case (cls_q)
            ClsSubu, ClsBeq: aluSelect = 3'b001;
            ClsOri:          aluSelect = 3'b010;
            ClsSlt:          aluSelect = 3'b011;
            ClsAddi:         aluSelect = 3'b100;
            ClsLui:          aluSelect = 3'b101;
            default:         aluSelect = 3'b000;
          endcase
          case (cls_q)
            ClsAddu, ClsSubu, ClsSlt, ClsBeq: alu_srcB = 2'b00;
            ClsAddi, ClsAddiu, ClsLw, ClsSw:  alu_srcB = 2'b10;
            ClsOri, ClsLui:                   alu_srcB = 2'b11;
            default:                          alu_srcB = 2'b01;
          endcase
          case (cls_q)
            ClsBeq: begin
              if (flag_zero) begin
                pc_write = 1'b1;
                pc_src   = 2'b01;
              end
              state_d = StIf;
            end
            ClsJ: begin
              pc_write = 1'b1;
              pc_src   = 2'b10;
              state_d  = StIf;
            end
            ClsLw, ClsSw: state_d = StMem;
            ClsNone:      state_d = StIf;
            default: begin
`ifdef OVF_TRAP_EN
              state_d = (cls_q == ClsAddi && flag_overflow_pos) ? StExc : StWb;
`else
              state_d = StWb;
`endif
            end
          endcase
        end
        StMem: begin
          if (cls_q == ClsLw) mem_read  = 1'b1;
          else                mem_write = 1'b1;
          if (mem_ready) state_d = (cls_q == ClsLw) ? StWb : StIf;
          else           state_d = StMem;
        end
        StWb: begin
          reg_write  = 1'b1;
          reg_dst    = (cls_q == ClsAddu || cls_q == ClsSubu || cls_q == ClsSlt);
          mem_to_reg = (cls_q == ClsLw);
          state_d    = StIf;
        end
        StExc: begin
          exc_c   = 1'b1;
          state_d = StIf;
        end
        default: state_d = StIf;
      endcase
    end
  end

`ifdef OVF_TRAP_EN
  assign exc = exc_c;
`else
  assign exc = 1'b0;
  logic unused_ovf;
  assign unused_ovf = flag_overflow_pos ^ exc_c;
`endif

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       mem_ready, flag_zero, flag_overflow_pos;
  logic [2:0] aluSelect;
  logic [1:0] alu_srcB;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write;
  logic [1:0] pc_src;
  logic       reg_dst, mem_to_reg, exc, illegal_op;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  logic [18:0] obs;
  logic [18:0] expv;

  multicycle_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .opcode            (opcode),
    .funct             (funct),
    .mem_ready         (mem_ready),
    .flag_zero         (flag_zero),
    .flag_overflow_pos (flag_overflow_pos),
    .aluSelect         (aluSelect),
    .alu_srcB          (alu_srcB),
    .pc_write          (pc_write),
    .ir_write          (ir_write),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .reg_write         (reg_write),
    .pc_src            (pc_src),
    .reg_dst           (reg_dst),
    .mem_to_reg        (mem_to_reg),
    .exc               (exc),
    .illegal_op        (illegal_op),
    .state             (state)
  );

  always #5 clk = ~clk;

  // Observed vector: state, aluSelect, alu_srcB,
  // {pc_write, ir_write, mem_read, mem_write, reg_write}, pc_src,
  // {reg_dst, mem_to_reg, exc, illegal_op}
  assign obs = {state, aluSelect, alu_srcB, pc_write, ir_write, mem_read, mem_write,
                reg_write, pc_src, reg_dst, mem_to_reg, exc, illegal_op};

  function automatic logic [18:0] ex(input logic [2:0] st, input logic [2:0] alu,
                                     input logic [1:0] sb, input logic [4:0] stb,
                                     input logic [1:0] ps, input logic [3:0] misc);
    return {st, alu, sb, stb, ps, misc};
  endfunction

  // Advance one clock; inputs are then changed and outputs sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 6'b000000; funct = 6'b100001;
    mem_ready = 1'b1; flag_zero = 1'b0; flag_overflow_pos = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    expv = ex(3'd0, 3'b000, 2'b01, 5'b00000, 2'b00, 4'b0000);
    checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL reset_outputs: got %b want %b", obs, expv);
    end
    rst_n = 1'b1; mem_ready = 1'b0; #1;
    expv = ex(3'd0, 3'b000, 2'b01, 5'b00100, 2'b00, 4'b0000);
    checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL reset_release_fetch: got %b want %b", obs, expv);
    end
    step();
    checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL if_wait_hold: got %b want %b", obs, expv);
    end
  endtask

  task automatic test_addu();
    opcode = 6'b000000; funct = 6'b100001; mem_ready = 1'b1; #1;
    expv = ex(3'd0, 3'b000, 2'b01, 5'b11100, 2'b00, 4'b0000);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL addu_if: got %b want %b", obs, expv); end
    step();
    expv = ex(3'd1, 3'b000, 2'b01, 5'b00000, 2'b00, 4'b0000);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL addu_id: got %b want %b", obs, expv); end
    step();
    expv = ex(3'd2, 3'b000, 2'b00, 5'b00000, 2'b00, 4'b0000);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL addu_ex: got %b want %b", obs, expv); end
    step();
    expv = ex(3'd4, 3'b000, 2'b01, 5'b00001, 2'b00, 4'b1000);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL addu_wb: got %b want %b", obs, expv); end
    step();
    mem_ready = 1'b0; #1;
    expv = ex(3'd0, 3'b000, 2'b01, 5'b00100, 2'b00, 4'b0000);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL addu_ret: got %b want %b", obs, expv); end
  endtask

  // Table entries: {opcode, funct, ex aluSelect, ex alu_srcB, wb reg_dst}
  task automatic test_alu_ops();
    logic [17:0] tbl [6];
    tbl[0] = {6'b000000, 6'b100011, 3'b001, 2'b00, 1'b1};  // subu
    tbl[1] = {6'b000000, 6'b101010, 3'b011, 2'b00, 1'b1};  // slt
    tbl[2] = {6'b001001, 6'b000000, 3'b000, 2'b10, 1'b0};  // addiu
    tbl[3] = {6'b001101, 6'b111111, 3'b010, 2'b11, 1'b0};  // ori
    tbl[4] = {6'b001111, 6'b000000, 3'b101, 2'b11, 1'b0};  // lui
    tbl[5] = {6'b001000, 6'b000000, 3'b100, 2'b10, 1'b0};  // addi, no overflow
    for (int i = 0; i < 6; i++) begin
      opcode = tbl[i][17:12]; funct = tbl[i][11:6]; mem_ready = 1'b1;
      flag_overflow_pos = 1'b0;
      step(); step();
      expv = ex(3'd2, tbl[i][5:3], tbl[i][2:1], 5'b00000, 2'b00, 4'b0000);
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL aluop%0d_ex: got %b want %b", i, obs, expv);
      end
      step();
      expv = ex(3'd4, 3'b000, 2'b01, 5'b00001, 2'b00, {tbl[i][0], 3'b000});
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL aluop%0d_wb: got %b want %b", i, obs, expv);
      end
      step();
      mem_ready = 1'b0; #1;
    end
  endtask

  task automatic test_lw_wait();
    int n = 0;
    opcode = 6'b100011; funct = 6'b000000; mem_ready = 1'b1;
    step(); n++;
    step(); n++;
    expv = ex(3'd2, 3'b000, 2'b10, 5'b00000, 2'b00, 4'b0000);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL lw_ex: got %b want %b", obs, expv); end
    step(); n++;
    mem_ready = 1'b0; #1;
    expv = ex(3'd3, 3'b000, 2'b01, 5'b00100, 2'b00, 4'b0000);
    for (int w = 0; w < 3; w++) begin
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL lw_mem_wait%0d: got %b want %b", w, obs, expv);
      end
      step(); n++;
    end
    mem_ready = 1'b1; #1;
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL lw_mem_done: got %b want %b", obs, expv); end
    step(); n++;
    expv = ex(3'd4, 3'b000, 2'b01, 5'b00001, 2'b00, 4'b0100);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL lw_wb: got %b want %b", obs, expv); end
    step(); n++;
    mem_ready = 1'b0; #1;
    expv = ex(3'd0, 3'b000, 2'b01, 5'b00100, 2'b00, 4'b0000);
    checks++;
    if (obs !== expv || n != 8) begin
      failures++; $display("FAIL lw_latency: got %b/%0d want %b/8", obs, n, expv);
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      opcode = 6'b000100; funct = 6'b000000; mem_ready = 1'b1; flag_zero = z[0];
      step(); step();
      expv = (z == 1) ? ex(3'd2, 3'b001, 2'b00, 5'b10000, 2'b01, 4'b0000)
                      : ex(3'd2, 3'b001, 2'b00, 5'b00000, 2'b00, 4'b0000);
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL beq_ex_z%0d: got %b want %b", z, obs, expv);
      end
      step();
      mem_ready = 1'b0; #1;
      expv = ex(3'd0, 3'b000, 2'b01, 5'b00100, 2'b00, 4'b0000);
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL beq_ret_z%0d: got %b want %b", z, obs, expv);
      end
    end
    flag_zero = 1'b0;
  endtask

  task automatic test_j();
    opcode = 6'b000010; funct = 6'b000000; mem_ready = 1'b1;
    step(); step();
    expv = ex(3'd2, 3'b000, 2'b01, 5'b10000, 2'b10, 4'b0000);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL j_ex: got %b want %b", obs, expv); end
    step();
    mem_ready = 1'b0; #1;
    expv = ex(3'd0, 3'b000, 2'b01, 5'b00100, 2'b00, 4'b0000);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL j_ret: got %b want %b", obs, expv); end
  endtask

  task automatic test_addi_ovf();
    opcode = 6'b001000; funct = 6'b000000; mem_ready = 1'b1; flag_overflow_pos = 1'b1;
    step(); step();
    expv = ex(3'd2, 3'b100, 2'b10, 5'b00000, 2'b00, 4'b0000);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL addi_ovf_ex: got %b want %b", obs, expv); end
    step();
`ifdef OVF_TRAP_EN
    expv = ex(3'd5, 3'b000, 2'b01, 5'b00000, 2'b00, 4'b0010);
`else
    expv = ex(3'd4, 3'b000, 2'b01, 5'b00001, 2'b00, 4'b0000);
`endif
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL addi_ovf_next: got %b want %b", obs, expv); end
    step();
    mem_ready = 1'b0; flag_overflow_pos = 1'b0; #1;
    expv = ex(3'd0, 3'b000, 2'b01, 5'b00100, 2'b00, 4'b0000);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL addi_ovf_ret: got %b want %b", obs, expv); end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111; funct = 6'b000000; mem_ready = 1'b1;
    step();
    expv = ex(3'd1, 3'b000, 2'b01, 5'b00000, 2'b00, 4'b0001);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL illegal_id: got %b want %b", obs, expv); end
    step();
    mem_ready = 1'b0; #1;
    expv = ex(3'd0, 3'b000, 2'b01, 5'b00100, 2'b00, 4'b0000);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL illegal_ret: got %b want %b", obs, expv); end
  endtask

  task automatic test_sw_reset();
    opcode = 6'b101011; funct = 6'b000000; mem_ready = 1'b1;
    step(); step();
    expv = ex(3'd2, 3'b000, 2'b10, 5'b00000, 2'b00, 4'b0000);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL sw_ex: got %b want %b", obs, expv); end
    step();
    mem_ready = 1'b0; #1;
    expv = ex(3'd3, 3'b000, 2'b01, 5'b00010, 2'b00, 4'b0000);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL sw_mem_wait: got %b want %b", obs, expv); end
    rst_n = 1'b0; #1;
    expv = ex(3'd0, 3'b000, 2'b01, 5'b00000, 2'b00, 4'b0000);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL sw_async_rst: got %b want %b", obs, expv); end
    step();
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL sw_rst_hold: got %b want %b", obs, expv); end
    rst_n = 1'b1; opcode = 6'b000000; funct = 6'b100001; #1;
    expv = ex(3'd0, 3'b000, 2'b01, 5'b00100, 2'b00, 4'b0000);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL sw_refetch: got %b want %b", obs, expv); end
    mem_ready = 1'b1; step();
    expv = ex(3'd1, 3'b000, 2'b01, 5'b00000, 2'b00, 4'b0000);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL sw_refetch_id: got %b want %b", obs, expv); end
    step();
    expv = ex(3'd2, 3'b000, 2'b00, 5'b00000, 2'b00, 4'b0000);
    checks++;
    if (obs !== expv) begin failures++; $display("FAIL sw_refetch_ex: got %b want %b", obs, expv); end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_alu_ops();
    test_lw_wait();
    test_beq();
    test_j();
    test_addi_ovf();
    test_illegal();
    test_sw_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
